// File: rtl/ysyx_041514_icache_refill.sv
// Purpose: icache miss/refill controller. It issues one 8-beat AXI4 INCR read for a
//   64-byte line, steers each 64-bit beat into a 128-bit bank half, then pulses the tag write.
// Latency: accept -> AR -> 8 beats -> DONE, 11 cycles minimum. It stalls on ar_ready_i and r_valid_i without a timeout.
// Backpressure: the block accepts a miss only in IDLE. r_ready_o is held high for the whole R phase.
// Ports: miss_* (request side), ar_*/r_* (AXI read master), icache_*/burst_count_o (data array),
//   tag_wen_o/tag_o (tag array), refill_done_o/refill_err_o (completion status), flush_i (fence.i).
module ysyx_041514_icache_refill #(
  parameter int IDX_LEN  = 6,
  parameter int BLK_LEN  = 6,
  parameter int ADDR_LEN = 32,
  parameter int TAG_LEN  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req_i,
  input  logic [ADDR_LEN-1:0] miss_addr_i,
  output logic                miss_ready_o,
  input  logic                flush_i,
  output logic                refill_done_o,
  output logic                refill_err_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output logic [ADDR_LEN-1:0] ar_addr_o,
  output logic [7:0]          ar_len_o,
  output logic [2:0]          ar_size_o,
  output logic [1:0]          ar_burst_o,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [63:0]         r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_last_i,
  output logic [IDX_LEN-1:0]  icache_index_o,
  output logic [127:0]        icache_line_wdata_o,
  output logic [127:0]        icache_wmask_o,
  output logic [2:0]          burst_count_o,
  output logic                icache_wen_o,
  output logic                tag_wen_o,
  output logic [TAG_LEN-1:0]  tag_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                     state;
  logic [ADDR_LEN-1:BLK_LEN]  line_addr;   // the byte offset is never needed, because the burst is line-aligned
  logic [2:0]                 beat_cnt;
  logic                       err;
  logic                       flush_seen;

  logic unused_offset;
  assign unused_offset = ^miss_addr_i[BLK_LEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      line_addr  <= '0;
      beat_cnt   <= 3'd0;
      err        <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // flush_i is ignored here, even when it arrives together with a new miss.
          if (miss_req_i) begin
            line_addr  <= miss_addr_i[ADDR_LEN-1:BLK_LEN];
            beat_cnt   <= 3'd0;
            err        <= 1'b0;
            flush_seen <= 1'b0;
            state      <= S_AR;
          end
        end
        S_AR: begin
          if (flush_i)    flush_seen <= 1'b1;
          if (ar_ready_i) state      <= S_R;
        end
        S_R: begin
          if (flush_i) flush_seen <= 1'b1;
          if (r_valid_i) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (r_resp_i != 2'b00) err <= 1'b1;
            if (beat_cnt == 3'd7) begin
              // The eighth beat ends the refill. If the slave has not flagged last, the burst length was wrong.
              state <= S_DONE;
              if (!r_last_i) err <= 1'b1;
            end else if (r_last_i) begin
              // A short burst leaves stale banks, so the line must not become valid.
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (flush_i) flush_seen <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign miss_ready_o = (state == S_IDLE);

  assign ar_valid_o = (state == S_AR);
  assign ar_addr_o  = {line_addr, {BLK_LEN{1'b0}}};
  assign ar_len_o   = 8'd7;
  assign ar_size_o  = 3'b011;
  assign ar_burst_o = 2'b01;

  assign r_ready_o           = (state == S_R);
  assign icache_wen_o        = (state == S_R) & r_valid_i;
  assign burst_count_o       = beat_cnt;
  assign icache_line_wdata_o = {r_data_i, r_data_i};
  // Odd beats fill the upper half of the bank, and even beats fill the lower half.
  assign icache_wmask_o      = beat_cnt[0] ? {{64{1'b1}}, {64{1'b0}}} : {{64{1'b0}}, {64{1'b1}}};

  assign icache_index_o = line_addr[BLK_LEN+IDX_LEN-1:BLK_LEN];
  assign tag_o          = line_addr[ADDR_LEN-1:ADDR_LEN-TAG_LEN];

  assign refill_done_o = (state == S_DONE);
  assign refill_err_o  = (state == S_DONE) & err;
  // A flush in the DONE cycle itself also blocks the tag write.
  assign tag_wen_o     = (state == S_DONE) & ~err & ~flush_seen & ~flush_i;

endmodule

// File: tb/tb_ysyx_041514_icache_refill.sv
module tb_ysyx_041514_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         miss_ready_o;
  logic         flush_i;
  logic         refill_done_o;
  logic         refill_err_o;
  logic         ar_valid_o;
  logic         ar_ready_i;
  logic [31:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [1:0]   ar_burst_o;
  logic         r_valid_i;
  logic         r_ready_o;
  logic [63:0]  r_data_i;
  logic [1:0]   r_resp_i;
  logic         r_last_i;
  logic [5:0]   icache_index_o;
  logic [127:0] icache_line_wdata_o;
  logic [127:0] icache_wmask_o;
  logic [2:0]   burst_count_o;
  logic         icache_wen_o;
  logic         tag_wen_o;
  logic [19:0]  tag_o;

  always #5 clk = ~clk;

  ysyx_041514_icache_refill dut (
    .clk(clk), .rst(rst),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
    .flush_i(flush_i), .refill_done_o(refill_done_o), .refill_err_o(refill_err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .icache_index_o(icache_index_o), .icache_line_wdata_o(icache_line_wdata_o),
    .icache_wmask_o(icache_wmask_o), .burst_count_o(burst_count_o),
    .icache_wen_o(icache_wen_o), .tag_wen_o(tag_wen_o), .tag_o(tag_o)
  );

  int checks = 0;
  int errors = 0;

  // err_beat/rst_beat: -1 means none. last_beat: 7 is normal, 0..6 is early, and 8 means it is never asserted.
  // flush_at: -3 = with the accepted miss, -2 = none, -1 = on the AR handshake cycle, 0..7 = on that beat, 8 = in DONE.
  typedef struct {
    logic [31:0] addr;
    int          ar_wait;
    bit          gap;
    int          err_beat;
    int          last_beat;
    int          flush_at;
    int          rst_beat;
    bit          exp_err;
    bit          exp_tag;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference outcome, derived from the line-refill rules rather than from cycle behaviour.
  function automatic void model(input vec_t v, output bit e, output bit t);
    int  nsent;
    bit  f;
    nsent = (v.last_beat < 7) ? v.last_beat + 1 : 8;
    e = (v.err_beat >= 0 && v.err_beat < nsent) || (v.last_beat != 7);
    f = (v.flush_at == -1) || (v.flush_at == 8) || (v.flush_at >= 0 && v.flush_at < nsent);
    t = !e && !f;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_miss_ready"}, miss_ready_o, 1);
    chk({tag, "_ar_valid"}, ar_valid_o, 0);
    chk({tag, "_r_ready"}, r_ready_o, 0);
    chk({tag, "_wen"}, icache_wen_o, 0);
    chk({tag, "_done"}, refill_done_o, 0);
    chk({tag, "_err"}, refill_err_o, 0);
    chk({tag, "_tag_wen"}, tag_wen_o, 0);
  endtask

  // This task is entered #1 after a clock edge with the DUT in IDLE, and it leaves the DUT in the same position.
  task automatic run_refill(input vec_t v);
    int            nsent;
    logic [63:0]   d;
    logic [127:0]  exp_mask;
    logic [31:0]   line;
    nsent = (v.last_beat < 7) ? v.last_beat + 1 : 8;
    line  = v.addr & 32'hFFFF_FFC0;

    miss_req_i  = 1'b1;
    miss_addr_i = v.addr;
    flush_i     = (v.flush_at == -3);
    #1 chk("accept_ready", miss_ready_o, 1);
    step();
    miss_req_i  = 1'b0;
    flush_i     = 1'b0;
    miss_addr_i = $urandom;  // the latched address must not follow the input

    for (int w = 0; w < v.ar_wait; w++) begin
      #1;
      chk("ar_wait_valid", ar_valid_o, 1);
      chk("ar_wait_addr", ar_addr_o, line);
      chk("ar_wait_ready_lo", miss_ready_o, 0);
      step();
    end
    ar_ready_i = 1'b1;
    flush_i    = (v.flush_at == -1);
    #1;
    chk("ar_valid", ar_valid_o, 1);
    chk("ar_addr", ar_addr_o, line);
    chk("ar_len", ar_len_o, 7);
    chk("ar_size", ar_size_o, 3);
    chk("ar_burst", ar_burst_o, 1);
    step();
    ar_ready_i = 1'b0;
    flush_i    = 1'b0;

    for (int i = 0; i < nsent; i++) begin
      if (v.gap && i > 0) begin
        r_valid_i = 1'b0;
        #1;
        chk("gap_wen", icache_wen_o, 0);
        chk("gap_r_ready", r_ready_o, 1);
        step();
      end
      d         = {$urandom, $urandom};
      r_valid_i = 1'b1;
      r_data_i  = d;
      r_resp_i  = (i == v.err_beat) ? 2'b10 : 2'b00;
      r_last_i  = (i == v.last_beat);
      flush_i   = (i == v.flush_at);
      exp_mask  = (i % 2 == 1) ? {{64{1'b1}}, {64{1'b0}}} : {{64{1'b0}}, {64{1'b1}}};
      #1;
      chk("beat_wen", icache_wen_o, 1);
      chk("beat_count", burst_count_o, i[2:0]);
      chk("beat_mask", icache_wmask_o, exp_mask);
      chk("beat_wdata", icache_line_wdata_o, {d, d});
      chk("beat_index", icache_index_o, v.addr[11:6]);
      chk("beat_done_lo", refill_done_o, 0);
      if (i == v.rst_beat) begin
        rst = 1'b1;
        step();
        rst       = 1'b0;
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        r_resp_i  = 2'b00;
        flush_i   = 1'b0;
        #1;
        check_idle("after_rst");
        return;
      end
      step();
    end
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    r_resp_i  = 2'b00;
    flush_i   = (v.flush_at == 8);
    #1;
    chk("done", refill_done_o, 1);
    chk("done_err", refill_err_o, v.exp_err);
    chk("done_tag_wen", tag_wen_o, v.exp_tag);
    chk("done_tag", tag_o, v.addr[31:12]);
    chk("done_wen_lo", icache_wen_o, 0);
    step();
    flush_i = 1'b0;
    #1;
    check_idle("post_done");
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    bit   me, mt;
    int   r;
    vecs[0] = '{32'h8000_1234, 0, 0, -1, 7, -2, -1, 0, 1};
    vecs[1] = '{32'h8000_1234, 3, 1, -1, 7, -2, -1, 0, 1};
    vecs[2] = '{32'h1234_5678, 0, 0,  3, 7, -2, -1, 1, 0};
    vecs[3] = '{32'h0000_0047, 0, 0, -1, 5, -2, -1, 1, 0};
    vecs[4] = '{32'h8000_1234, 0, 0, -1, 7,  2, -1, 0, 0};
    vecs[5] = '{32'hFFFF_FFFF, 1, 0, -1, 7, -3, -1, 0, 1};
    vecs[6] = '{32'h8000_0000, 0, 1, -1, 8, -2, -1, 1, 0};
    vecs[7] = '{32'h0000_0000, 0, 0, -1, 7,  8, -1, 0, 0};
    vecs[8] = '{32'h8000_1234, 0, 0, -1, 7, -2,  4, 0, 0};
    vecs[9] = '{32'hA5A5_5A5A, 2, 0, -1, 7, -1, -1, 0, 0};

    rst = 1'b1; miss_req_i = 1'b0; miss_addr_i = '0; flush_i = 1'b0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle("reset");
    chk("reset_burst_count", burst_count_o, 0);

    for (int k = 0; k < 10; k++) run_refill(vecs[k]);

    for (int k = 0; k < 24; k++) begin
      v.addr     = $urandom;
      v.ar_wait  = int'($urandom_range(0, 3));
      v.gap      = 1'($urandom_range(0, 1));
      v.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      r = int'($urandom_range(0, 5));
      v.last_beat = (r == 0) ? int'($urandom_range(0, 6)) : (r == 1) ? 8 : 7;
      r = int'($urandom_range(0, 7));
      case (r)
        0: v.flush_at = int'($urandom_range(0, 7));
        1: v.flush_at = -1;
        2: v.flush_at = 8;
        3: v.flush_at = -3;
        default: v.flush_at = -2;
      endcase
      v.rst_beat = -1;
      model(v, me, mt);
      v.exp_err = me;
      v.exp_tag = mt;
      run_refill(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
